i2c_slave_ctrl: RTL and testbench

I2C_SLAVE_CTRL -- requirements
Module: i2c_slave_ctrl

---
 rtl/myfilter_pkg.sv | 22 ++
 rtl/i2c_slave_ctrl_sync_edge.sv | 52 +++++
 rtl/i2c_slave_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_i2c_slave_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/myfilter_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | myfilter_pkg : state encoding and ACK levels for the I2C slave        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package myfilter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ACK_ADDR = 3'd2,
    ST_RX       = 3'd3,
    ST_ACK_RX   = 3'd4,
    ST_TX       = 3'd5,
    ST_MACK     = 3'd6
  } i2c_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage
`default_nettype wire

// File: rtl/i2c_slave_ctrl_sync_edge.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | i2c_sync_edge : SCL/SDA synchronizer, SCL edge and START/STOP detect  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic                   w_scl;
  logic                   w_sda;

  // Reset to the idle bus level so no edge is seen while the chain refills.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign o_sda      = w_sda;
  assign o_scl_rise = w_scl & ~r_scl_d;
  assign o_scl_fall = ~w_scl & r_scl_d;
  // SCL must be high in both samples so an SCL edge never looks like START/STOP.
  assign o_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign o_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

endmodule
`default_nettype wire

// File: rtl/i2c_slave_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | i2c_slave_ctrl : 7-bit address I2C slave, byte read/write, no stretch |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module i2c_slave_ctrl
  import myfilter_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  input  logic [7:0] tx_data_in,
  output logic       oe_out,
  output logic       osel_out,
  output logic       ack_out,
  output logic       sd_out,
  output logic [7:0] rx_data_out,
  output logic       rx_valid_out,
  output logic       tx_load_out,
  output logic       busy_out
);

  logic w_sda, w_rise, w_fall, w_start, w_stop;

  i2c_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk        (clk),
    .rst        (rst),
    .i_scl      (scl_in),
    .i_sda      (sda_in),
    .o_sda      (w_sda),
    .o_scl_rise (w_rise),
    .o_scl_fall (w_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  i2c_state_t r_state, w_state_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic       r_phase, w_phase_nxt;
  logic       r_rw, w_rw_nxt;
  logic [6:0] r_shreg, w_shreg_nxt;
  logic [6:0] r_tx_sh, w_tx_sh_nxt;
  logic [7:0] r_rx_data, w_rx_data_nxt;
  logic       r_rx_valid, w_rx_valid_nxt;
  logic       r_tx_load, w_tx_load_nxt;
  logic       r_oe, w_oe_nxt;
  logic       r_osel, w_osel_nxt;
  logic       r_ack, w_ack_nxt;
  logic       r_sd, w_sd_nxt;
  logic       r_busy, w_busy_nxt;

  // r_phase: in ACK states, set once the ACK is on the bus; in MACK, set once
  // the master's ACK has been sampled.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_phase_nxt    = r_phase;
    w_rw_nxt       = r_rw;
    w_shreg_nxt    = r_shreg;
    w_tx_sh_nxt    = r_tx_sh;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = 1'b0;
    w_tx_load_nxt  = 1'b0;
    w_oe_nxt       = r_oe;
    w_osel_nxt     = r_osel;
    w_ack_nxt      = r_ack;
    w_sd_nxt       = r_sd;
    w_busy_nxt     = r_busy;

    if (w_start) begin
      w_state_nxt = ST_ADDR;
      w_cnt_nxt   = 3'd0;
      w_phase_nxt = 1'b0;
      w_oe_nxt    = 1'b0;
      w_osel_nxt  = 1'b0;
      w_ack_nxt   = I2C_NACK;
    end else if (w_stop) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = 3'd0;
      w_phase_nxt = 1'b0;
      w_oe_nxt    = 1'b0;
      w_osel_nxt  = 1'b0;
      w_ack_nxt   = I2C_NACK;
      w_sd_nxt    = 1'b1;
      w_busy_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR: begin
          if (w_rise) begin
            w_shreg_nxt = {r_shreg[5:0], w_sda};
            w_cnt_nxt   = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              if (r_shreg == SLAVE_ADDR) begin
                w_state_nxt = ST_ACK_ADDR;
                w_rw_nxt    = w_sda;
                w_busy_nxt  = 1'b1;
                w_phase_nxt = 1'b0;
              end else begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
              end
            end
          end
        end

        ST_ACK_ADDR, ST_ACK_RX: begin
          if (w_fall) begin
            if (!r_phase) begin
              w_oe_nxt    = 1'b1;
              w_osel_nxt  = 1'b0;
              w_ack_nxt   = I2C_ACK;
              w_phase_nxt = 1'b1;
            end else begin
              w_phase_nxt = 1'b0;
              w_cnt_nxt   = 3'd0;
              w_ack_nxt   = I2C_NACK;
              if (r_state == ST_ACK_ADDR && r_rw) begin
                w_tx_sh_nxt   = tx_data_in[6:0];
                w_sd_nxt      = tx_data_in[7];
                w_tx_load_nxt = 1'b1;
                w_osel_nxt    = 1'b1;
                w_state_nxt   = ST_TX;
              end else begin
                w_oe_nxt    = 1'b0;
                w_state_nxt = ST_RX;
              end
            end
          end
        end

        ST_RX: begin
          if (w_rise) begin
            w_shreg_nxt = {r_shreg[5:0], w_sda};
            w_cnt_nxt   = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              w_rx_data_nxt  = {r_shreg, w_sda};
              w_rx_valid_nxt = 1'b1;
              w_phase_nxt    = 1'b0;
              w_state_nxt    = ST_ACK_RX;
            end
          end
        end

        ST_TX: begin
          if (w_fall) begin
            if (r_cnt == 3'd7) begin
              w_oe_nxt    = 1'b0;
              w_cnt_nxt   = 3'd0;
              w_phase_nxt = 1'b0;
              w_state_nxt = ST_MACK;
            end else begin
              w_cnt_nxt   = r_cnt + 3'd1;
              w_sd_nxt    = r_tx_sh[6];
              w_tx_sh_nxt = {r_tx_sh[5:0], 1'b0};
            end
          end
        end

        ST_MACK: begin
          if (w_rise) begin
            if (w_sda == I2C_NACK) begin
              w_state_nxt = ST_IDLE;
              w_busy_nxt  = 1'b0;
              w_osel_nxt  = 1'b0;
              w_sd_nxt    = 1'b1;
            end else begin
              w_phase_nxt = 1'b1;
            end
          end else if (w_fall && r_phase) begin
            w_tx_sh_nxt   = tx_data_in[6:0];
            w_sd_nxt      = tx_data_in[7];
            w_tx_load_nxt = 1'b1;
            w_oe_nxt      = 1'b1;
            w_osel_nxt    = 1'b1;
            w_cnt_nxt     = 3'd0;
            w_phase_nxt   = 1'b0;
            w_state_nxt   = ST_TX;
          end
        end

        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 3'd0;
      r_phase    <= 1'b0;
      r_rw       <= 1'b0;
      r_shreg    <= 7'd0;
      r_tx_sh    <= 7'd0;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_tx_load  <= 1'b0;
      r_oe       <= 1'b0;
      r_osel     <= 1'b0;
      r_ack      <= I2C_NACK;
      r_sd       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_phase    <= w_phase_nxt;
      r_rw       <= w_rw_nxt;
      r_shreg    <= w_shreg_nxt;
      r_tx_sh    <= w_tx_sh_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_tx_load  <= w_tx_load_nxt;
      r_oe       <= w_oe_nxt;
      r_osel     <= w_osel_nxt;
      r_ack      <= w_ack_nxt;
      r_sd       <= w_sd_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  // Only the driving states may enable the pad, whatever r_oe holds.
  assign oe_out       = r_oe & ((r_state == ST_ACK_ADDR) || (r_state == ST_ACK_RX) ||
                                (r_state == ST_TX));
  assign osel_out     = r_osel;
  assign ack_out      = r_ack;
  assign sd_out       = r_sd;
  assign rx_data_out  = r_rx_data;
  assign rx_valid_out = r_rx_valid;
  assign tx_load_out  = r_tx_load;
  assign busy_out     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_i2c_slave_ctrl : directed bus-level bench for i2c_slave_ctrl       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_i2c_slave_ctrl;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic [7:0] tx_data = 8'h00;
  logic       oe_out, osel_out, ack_out, sd_out;
  logic [7:0] rx_data_out;
  logic       rx_valid_out, tx_load_out, busy_out;

  int n_checks = 0;
  int n_errors = 0;
  int rxv_cnt  = 0;
  int txl_cnt  = 0;
  int oe_cnt   = 0;

  always #5 clk = ~clk;

  // Open-drain bus: the slave can only pull SDA low through the output mux.
  assign sda_bus = sda_m & ~(oe_out & ~(osel_out ? sd_out : ack_out));

  i2c_slave_ctrl #(
    .SLAVE_ADDR  (7'h42),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .scl_in       (scl_m),
    .sda_in       (sda_bus),
    .tx_data_in   (tx_data),
    .oe_out       (oe_out),
    .osel_out     (osel_out),
    .ack_out      (ack_out),
    .sd_out       (sd_out),
    .rx_data_out  (rx_data_out),
    .rx_valid_out (rx_valid_out),
    .tx_load_out  (tx_load_out),
    .busy_out     (busy_out)
  );

  always @(negedge clk) begin
    if (rx_valid_out) rxv_cnt <= rxv_cnt + 1;
    if (tx_load_out)  txl_cnt <= txl_cnt + 1;
    if (oe_out)       oe_cnt  <= oe_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bit_cycle(input logic b, output logic rd);
    sda_m = b;
    wait_q();
    scl_m = 1'b1;
    wait_q();
    rd = sda_bus;
    wait_q();
    scl_m = 1'b0;
    wait_q();
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic rd;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], rd);
    bit_cycle(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic rd;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, rd);
      d[i] = rd;
    end
    bit_cycle(mack, rd);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int         rxv0, txl0, oe0;

    repeat (5) @(negedge clk);
    chk("reset_flags", {oe_out, osel_out, ack_out, sd_out, rx_valid_out, tx_load_out, busy_out},
        7'b0011000);
    chk("reset_rx_data", rx_data_out, 8'h00);
    rst = 1'b0;
    wait_q();

    // Write 0xA5 to 0x42
    rxv0 = rxv_cnt;
    i2c_start();
    write_byte(8'h84, ack);  chk("wr_addr_ack", ack, 1'b0);
    chk("wr_busy", busy_out, 1'b1);
    write_byte(8'hA5, ack);  chk("wr_data_ack", ack, 1'b0);
    chk("wr_rx_data", rx_data_out, 8'hA5);
    chk("wr_rxv_pulses", rxv_cnt - rxv0, 1);
    i2c_stop();
    wait_q();
    chk("wr_busy_after_stop", busy_out, 1'b0);

    // Address mismatch
    rxv0 = rxv_cnt; oe0 = oe_cnt;
    i2c_start();
    write_byte(8'h86, ack);  chk("mm_addr_nack", ack, 1'b1);
    write_byte(8'h11, ack);  chk("mm_data_nack", ack, 1'b1);
    chk("mm_oe_never", oe_cnt - oe0, 0);
    chk("mm_rxv_never", rxv_cnt - rxv0, 0);
    chk("mm_busy", busy_out, 1'b0);
    i2c_stop();
    wait_q();

    // Read two bytes, ACK then NACK
    txl0 = txl_cnt;
    tx_data = 8'h3C;
    i2c_start();
    write_byte(8'h85, ack);  chk("rd_addr_ack", ack, 1'b0);
    tx_data = 8'hC1;
    read_byte(1'b0, d);      chk("rd_byte0", d, 8'h3C);
    chk("rd_busy_mid", busy_out, 1'b1);
    read_byte(1'b1, d);      chk("rd_byte1", d, 8'hC1);
    chk("rd_tx_loads", txl_cnt - txl0, 2);
    chk("rd_idle_busy", busy_out, 1'b0);
    chk("rd_idle_oe", oe_out, 1'b0);
    i2c_stop();
    wait_q();

    // Write then repeated START into a read
    i2c_start();
    write_byte(8'h84, ack);  chk("rs_addr_ack", ack, 1'b0);
    write_byte(8'h55, ack);  chk("rs_data_ack", ack, 1'b0);
    tx_data = 8'h9A;
    i2c_start();
    write_byte(8'h85, ack);  chk("rs_raddr_ack", ack, 1'b0);
    chk("rs_rx_data", rx_data_out, 8'h55);
    read_byte(1'b1, d);      chk("rs_tx_byte", d, 8'h9A);
    i2c_stop();
    wait_q();

    // Reset during bit 4 of a data byte
    i2c_start();
    write_byte(8'h84, ack);  chk("rst_addr_ack", ack, 1'b0);
    bit_cycle(1'b1, ack);
    bit_cycle(1'b1, ack);
    bit_cycle(1'b1, ack);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    chk("rst_busy_before", busy_out, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_flags", {oe_out, osel_out, ack_out, sd_out, rx_valid_out, tx_load_out, busy_out},
        7'b0011000);
    chk("rst_mid_rx_data", rx_data_out, 8'h00);
    rst = 1'b0;
    oe0 = oe_cnt; rxv0 = rxv_cnt;
    wait_q();
    scl_m = 1'b0; wait_q();
    for (int i = 0; i < 4; i++) bit_cycle(1'b0, ack);
    bit_cycle(1'b1, ack);    chk("rst_rest_ignored", ack, 1'b1);
    chk("rst_oe_quiet", oe_cnt - oe0, 0);
    chk("rst_rxv_quiet", rxv_cnt - rxv0, 0);
    i2c_stop();
    wait_q();
    i2c_start();
    write_byte(8'h84, ack);  chk("post_rst_addr_ack", ack, 1'b0);
    write_byte(8'h0F, ack);  chk("post_rst_data_ack", ack, 1'b0);
    chk("post_rst_rx_data", rx_data_out, 8'h0F);
    i2c_stop();
    wait_q();

    // SDA toggles while SCL is low must not disturb a byte in progress
    i2c_start();
    write_byte(8'h84, ack);  chk("tg_addr_ack", ack, 1'b0);
    rxv0 = rxv_cnt;
    for (int i = 0; i < 6; i++) begin
      sda_m = ~sda_m;
      repeat (3) @(negedge clk);
    end
    chk("tg_busy", busy_out, 1'b1);
    chk("tg_oe", oe_out, 1'b0);
    write_byte(8'h3A, ack);  chk("tg_data_ack", ack, 1'b0);
    chk("tg_rx_data", rx_data_out, 8'h3A);
    chk("tg_rxv_once", rxv_cnt - rxv0, 1);
    i2c_stop();
    wait_q();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
